// File: rtl/vm_pkg.sv
// Shared types and constants for the coin acceptor front end.
package vm_pkg;

    // Default width of the credit / cash / refund buses.
    localparam int DEFAULT_CASH_W = 6;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_ISSUE   = 2'd2,
        ST_REFUND  = 2'd3
    } state_t;

    // Coin denominations indexed by coin_type.
    localparam int unsigned COIN_VAL [4] = '{1, 5, 10, 25};

    // Product codes as seen by the vending machine.
    localparam logic [1:0] PROD1        = 2'b00;
    localparam logic [1:0] PROD2        = 2'b01;
    localparam logic [1:0] PROD3        = 2'b10;
    localparam logic [1:0] PROD_INVALID = 2'b11;

    // Face value of a coin code.
    function automatic int unsigned coin_value(input logic [1:0] coin_type);
        return COIN_VAL[coin_type];
    endfunction

endpackage

// File: rtl/idle_timer.sv
// Idle timeout counter: counts cycles while enabled, flags the last one.
module idle_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // A single-cycle timeout still needs a one-bit counter.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear wins over count; the counter sits at zero whenever disabled.
    always_comb begin
        count_d = '0;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The owner leaves the counting state when this fires, so no wrap.
    assign expired = (count_q == LAST);

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: accumulates credit, latches selection, issues a one-cycle
// purchase or refund towards the downstream vending machine.
module coin_acceptor
    import vm_pkg::*;
#(
    parameter int CASH_W         = DEFAULT_CASH_W,
    parameter int MAX_CREDIT     = 63,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              coin_valid,
    input  logic [1:0]        coin_type,
    input  logic              sel_valid,
    input  logic [1:0]        sel,
    input  logic              cancel,
    output logic [CASH_W-1:0] cash,
    output logic              cash_valid,
    output logic [1:0]        product_sel,
    output logic [CASH_W-1:0] credit,
    output logic              coin_accept,
    output logic              coin_reject,
    output logic              refund_valid,
    output logic [CASH_W-1:0] refund_amount,
    output logic              busy
);

    localparam logic [CASH_W:0] MAX_SUM = (CASH_W + 1)'(MAX_CREDIT);

    state_t            state_q,         state_d;
    logic [CASH_W-1:0] credit_q,        credit_d;
    logic [CASH_W-1:0] cash_q,          cash_d;
    logic              cash_valid_q,    cash_valid_d;
    logic [1:0]        product_sel_q,   product_sel_d;
    logic              coin_accept_q,   coin_accept_d;
    logic              coin_reject_q,   coin_reject_d;
    logic              refund_valid_q,  refund_valid_d;
    logic [CASH_W-1:0] refund_amount_q, refund_amount_d;
    logic              busy_q,          busy_d;

    logic              timer_clr;
    logic              timer_en;
    logic              timer_expired;

    // The sum is one bit wider than credit so an over-limit coin cannot wrap.
    logic [CASH_W:0]   coin_val;
    logic [CASH_W:0]   credit_sum;
    logic              coin_fits;

    assign coin_val   = (CASH_W + 1)'(coin_value(coin_type));
    assign credit_sum = {1'b0, credit_q} + coin_val;
    assign coin_fits  = (credit_sum <= MAX_SUM);

    // Next-state and next-output logic; cancel/timeout > selection > coin.
    always_comb begin
        state_d         = state_q;
        credit_d        = credit_q;
        cash_d          = '0;
        cash_valid_d    = 1'b0;
        product_sel_d   = product_sel_q;
        coin_accept_d   = 1'b0;
        coin_reject_d   = 1'b0;
        refund_valid_d  = 1'b0;
        refund_amount_d = '0;
        busy_d          = 1'b0;
        timer_clr       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Only a coin can start a session; sel and cancel do nothing.
                if (coin_valid) begin
                    if (coin_fits) begin
                        credit_d      = credit_sum[CASH_W-1:0];
                        coin_accept_d = 1'b1;
                        timer_clr     = 1'b1;
                        state_d       = ST_COLLECT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end

            ST_COLLECT: begin
                if (cancel || timer_expired) begin
                    state_d         = ST_REFUND;
                    refund_valid_d  = 1'b1;
                    refund_amount_d = credit_q;
                    busy_d          = 1'b1;
                    coin_reject_d   = coin_valid;
                end else if (sel_valid && (sel != PROD_INVALID)) begin
                    state_d       = ST_ISSUE;
                    product_sel_d = sel;
                    cash_valid_d  = 1'b1;
                    cash_d        = credit_q;
                    busy_d        = 1'b1;
                    coin_reject_d = coin_valid;
                end else if (coin_valid) begin
                    if (coin_fits) begin
                        credit_d      = credit_sum[CASH_W-1:0];
                        coin_accept_d = 1'b1;
                        timer_clr     = 1'b1;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end

            // The strobe cycle: credit is dropped and no coin is taken.
            ST_ISSUE, ST_REFUND: begin
                credit_d      = '0;
                coin_reject_d = coin_valid;
                state_d       = ST_IDLE;
            end

            default: begin
                credit_d = '0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // The timer runs only across cycles that stay in COLLECT.
    assign timer_en = (state_d == ST_COLLECT);

    idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    // FSM state and all registered outputs; reset drops any held credit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            credit_q        <= '0;
            cash_q          <= '0;
            cash_valid_q    <= 1'b0;
            product_sel_q   <= PROD1;
            coin_accept_q   <= 1'b0;
            coin_reject_q   <= 1'b0;
            refund_valid_q  <= 1'b0;
            refund_amount_q <= '0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            credit_q        <= credit_d;
            cash_q          <= cash_d;
            cash_valid_q    <= cash_valid_d;
            product_sel_q   <= product_sel_d;
            coin_accept_q   <= coin_accept_d;
            coin_reject_q   <= coin_reject_d;
            refund_valid_q  <= refund_valid_d;
            refund_amount_q <= refund_amount_d;
            busy_q          <= busy_d;
        end
    end

    assign cash          = cash_q;
    assign cash_valid    = cash_valid_q;
    assign product_sel   = product_sel_q;
    assign credit        = credit_q;
    assign coin_accept   = coin_accept_q;
    assign coin_reject   = coin_reject_q;
    assign refund_valid  = refund_valid_q;
    assign refund_amount = refund_amount_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with a short idle timeout.
module tb_coin_acceptor;

    localparam int CASH_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              coin_valid;
    logic [1:0]        coin_type;
    logic              sel_valid;
    logic [1:0]        sel;
    logic              cancel;
    logic [CASH_W-1:0] cash;
    logic              cash_valid;
    logic [1:0]        product_sel;
    logic [CASH_W-1:0] credit;
    logic              coin_accept;
    logic              coin_reject;
    logic              refund_valid;
    logic [CASH_W-1:0] refund_amount;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;

    coin_acceptor #(
        .CASH_W         (CASH_W),
        .MAX_CREDIT     (63),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .coin_valid    (coin_valid),
        .coin_type     (coin_type),
        .sel_valid     (sel_valid),
        .sel           (sel),
        .cancel        (cancel),
        .cash          (cash),
        .cash_valid    (cash_valid),
        .product_sel   (product_sel),
        .credit        (credit),
        .coin_accept   (coin_accept),
        .coin_reject   (coin_reject),
        .refund_valid  (refund_valid),
        .refund_amount (refund_amount),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present inputs for one rising edge, then sample 1 time unit later.
    task automatic tick(input logic cv, input logic [1:0] ct, input logic sv,
                        input logic [1:0] s, input logic cn);
        coin_valid = cv;
        coin_type  = ct;
        sel_valid  = sv;
        sel        = s;
        cancel     = cn;
        @(posedge clk);
        #1;
        coin_valid = 1'b0;
        coin_type  = 2'd0;
        sel_valid  = 1'b0;
        sel        = 2'd0;
        cancel     = 1'b0;
        $display("t=%0t cv=%0d sv=%0d cn=%0d -> credit=%0d acc=%0d rej=%0d cv_o=%0d cash=%0d psel=%0d rv=%0d ramt=%0d busy=%0d",
                 $time, cv, sv, cn, credit, coin_accept, coin_reject, cash_valid, cash,
                 product_sel, refund_valid, refund_amount, busy);
    endtask

    task automatic idle();
        tick(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        rst        = 1'b0;
        coin_valid = 1'b0;
        coin_type  = 2'd0;
        sel_valid  = 1'b0;
        sel        = 2'd0;
        cancel     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_credit",     32'(credit), 0);
        check("rst_cash",       32'(cash), 0);
        check("rst_cash_valid", 32'(cash_valid), 0);
        check("rst_psel",       32'(product_sel), 0);
        check("rst_refund",     32'(refund_valid), 0);
        check("rst_busy",       32'(busy), 0);
        rst = 1'b1;
        idle();

        // Purchase: 10 + 10, select product 01.
        tick(1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
        check("p_acc1",    32'(coin_accept), 1);
        check("p_credit1", 32'(credit), 10);
        tick(1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
        check("p_credit2", 32'(credit), 20);
        tick(1'b0, 2'd0, 1'b1, 2'b01, 1'b0);
        check("p_cash_valid", 32'(cash_valid), 1);
        check("p_cash",       32'(cash), 20);
        check("p_psel",       32'(product_sel), 1);
        check("p_busy",       32'(busy), 1);
        idle();
        check("p_cash_valid_off", 32'(cash_valid), 0);
        check("p_cash_off",       32'(cash), 0);
        check("p_credit_clr",     32'(credit), 0);
        check("p_psel_hold",      32'(product_sel), 1);
        check("p_busy_off",       32'(busy), 0);

        // Over-limit coin: 50 + 25 rejected, then 50 + 10 accepted.
        tick(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
        tick(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
        check("ov_credit50", 32'(credit), 50);
        tick(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
        check("ov_reject",   32'(coin_reject), 1);
        check("ov_noacc",    32'(coin_accept), 0);
        check("ov_hold50",   32'(credit), 50);
        tick(1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
        check("ov_acc10",    32'(coin_accept), 1);
        check("ov_credit60", 32'(credit), 60);
        tick(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        check("ov_refund60", 32'(refund_amount), 60);
        idle();

        // Cancel with 15 held.
        tick(1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
        tick(1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
        check("cn_credit15", 32'(credit), 15);
        tick(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        check("cn_rv",      32'(refund_valid), 1);
        check("cn_ramt",    32'(refund_amount), 15);
        check("cn_no_cash", 32'(cash_valid), 0);
        idle();
        check("cn_rv_off",   32'(refund_valid), 0);
        check("cn_ramt_off", 32'(refund_amount), 0);
        check("cn_credit0",  32'(credit), 0);
        check("cn_no_cash2", 32'(cash_valid), 0);

        // Timeout: refund 16 edges after the accepting edge.
        tick(1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
        check("to_credit5", 32'(credit), 5);
        for (int i = 1; i <= 15; i++) begin
            idle();
            check($sformatf("to_wait%0d", i), 32'(refund_valid), 0);
        end
        idle();
        check("to_rv",   32'(refund_valid), 1);
        check("to_ramt", 32'(refund_amount), 5);
        idle();

        // Timeout restarted by a coin at edge 10.
        tick(1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
        for (int i = 1; i <= 9; i++) idle();
        tick(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        check("tr_credit6", 32'(credit), 6);
        for (int i = 1; i <= 15; i++) begin
            idle();
            check($sformatf("tr_wait%0d", i), 32'(refund_valid), 0);
        end
        idle();
        check("tr_rv",   32'(refund_valid), 1);
        check("tr_ramt", 32'(refund_amount), 6);
        idle();

        // Cancel + sel + coin together: cancel wins.
        tick(1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
        tick(1'b1, 2'd0, 1'b1, 2'b00, 1'b1);
        check("pr_rv",      32'(refund_valid), 1);
        check("pr_ramt",    32'(refund_amount), 10);
        check("pr_reject",  32'(coin_reject), 1);
        check("pr_no_cash", 32'(cash_valid), 0);
        check("pr_psel",    32'(product_sel), 1);
        idle();

        // Invalid selection is ignored.
        tick(1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
        tick(1'b0, 2'd0, 1'b1, 2'b11, 1'b0);
        check("inv_no_cash", 32'(cash_valid), 0);
        check("inv_busy",    32'(busy), 0);
        check("inv_credit",  32'(credit), 5);
        idle();
        check("inv_hold", 32'(credit), 5);

        // Sel + coin: sel wins; coin in ISSUE rejected; next coin accepted.
        tick(1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
        tick(1'b1, 2'd0, 1'b1, 2'b10, 1'b0);
        check("sc_cash_valid", 32'(cash_valid), 1);
        check("sc_cash",       32'(cash), 10);
        check("sc_reject",     32'(coin_reject), 1);
        check("sc_psel",       32'(product_sel), 2);
        tick(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        check("is_reject", 32'(coin_reject), 1);
        check("is_credit", 32'(credit), 0);
        tick(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        check("bb_accept", 32'(coin_accept), 1);
        check("bb_credit", 32'(credit), 1);
        tick(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        check("bb_ramt", 32'(refund_amount), 1);
        idle();

        // Asynchronous reset in COLLECT with 30 held.
        tick(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
        tick(1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
        check("ar_credit30", 32'(credit), 30);
        #3;
        rst = 1'b0;
        #1;
        check("ar_credit",  32'(credit), 0);
        check("ar_acc",     32'(coin_accept), 0);
        check("ar_psel",    32'(product_sel), 0);
        check("ar_rv",      32'(refund_valid), 0);
        check("ar_busy",    32'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        check("ar_rv_hold", 32'(refund_valid), 0);
        rst = 1'b1;
        tick(1'b0, 2'd0, 1'b1, 2'b01, 1'b0);
        check("ar_sel_ignored", 32'(cash_valid), 0);
        check("ar_psel_hold",   32'(product_sel), 0);
        tick(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        check("ar_cancel_ignored", 32'(refund_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end credit stage that sits directly upstream of `vendingmachine`. It accepts coin insertions, accumulates credit, and latches the customer's product selection. On a purchase it issues a one-cycle `cash`/`product_sel` presentation to the vending machine, which handles pricing, change and inventory. On a cancel or an idle timeout it returns the held credit as a refund.

## Interface
Parameters:
- `CASH_W`, 6: width of the credit, cash and refund buses; must match `vendingmachine.cash`.
- `MAX_CREDIT`, 63: highest credit value the block will hold.
- `TIMEOUT_CYCLES`, 1000: number of idle cycles in COLLECT before an automatic refund.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `coin_valid`  in  1  one-cycle strobe: a coin has been inserted.
- `coin_type`  in  2  coin denomination: 0→1, 1→5, 2→10, 3→25.
- `sel_valid`  in  1  one-cycle strobe: a selection button was pressed.
- `sel`  in  2  product code 00/01/10; 11 is invalid.
- `cancel`  in  1  one-cycle strobe: refund request.
- `cash`  out  CASH_W  credit presented to `vendingmachine`; 0 in every cycle where `cash_valid`=0.
- `cash_valid`  out  1  one-cycle purchase strobe.
- `product_sel`  out  2  latched selection; holds its value between purchases.
- `credit`  out  CASH_W  currently held credit.
- `coin_accept`  out  1  one-cycle acknowledgement of an accepted coin.
- `coin_reject`  out  1  one-cycle acknowledgement of a rejected coin.
- `refund_valid`  out  1  one-cycle refund strobe.
- `refund_amount`  out  CASH_W  refund value; 0 in every cycle where `refund_valid`=0.
- `busy`  out  1  high while in ISSUE or REFUND.

## Operation
- States: IDLE, COLLECT, ISSUE, REFUND.
- IDLE, credit=0:
  - Accepted coin: credit←value, go to COLLECT.
  - `sel_valid` and `cancel` are ignored.
- COLLECT:
  - Accepted coin: credit←credit+value.
  - Valid `sel_valid` (sel≠11): go to ISSUE.
  - `cancel` or timeout: go to REFUND.
- ISSUE, one cycle:
  - cash=credit, cash_valid=1.
  - Clear credit, go to IDLE.
- REFUND, one cycle:
  - refund_amount=credit, refund_valid=1.
  - Clear credit, go to IDLE.
- Coin acceptance:
  - A coin is accepted only if credit+value ≤ MAX_CREDIT.
  - Compute the sum at CASH_W+1 bits so no overflow wraps.
  - An over-limit coin is rejected and credit is unchanged.
- Simultaneous events in COLLECT: priority is cancel > sel_valid > coin_valid.
  - A coin arriving in the same cycle as a winning cancel or sel is rejected.
- Any coin that arrives during ISSUE or REFUND is rejected.
- `sel`=11 is ignored; the state stays COLLECT and the timer is not reset.
- Timeout counter:
  - Cleared on entry to COLLECT and on every accepted coin.
  - Increments each cycle in COLLECT.
  - Reaching TIMEOUT_CYCLES−1 forces REFUND.
  - Held at 0 in all other states.
- Reset clears every output and register: state=IDLE, credit=0, cash=0, product_sel=00, all strobes 0, timer=0.
  - A reset asserted mid-COLLECT discards the credit; no refund is issued.

## Timing
- `coin_valid` sampled at edge t: `coin_accept`/`coin_reject` high for the cycle after t, and `credit` updated at the same edge.
- `sel_valid` sampled at edge t: `product_sel` updated at t.
  - Over t..t+1: `cash_valid` high with `cash`=credit.
  - Credit reads 0 from edge t+1.
- `cancel` sampled at edge t: `refund_valid`/`refund_amount` high for one cycle after t.
- Back-to-back purchases: a new coin is accepted no earlier than the cycle after ISSUE.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Package `vm_pkg` holds:
  - the state enum;
  - coin-value constants COIN_VAL[0..3] = 1/5/10/25;
  - product codes PROD1=00, PROD2=01, PROD3=10, PROD_INVALID=11;
  - the CASH_W default.
- Sub-module `idle_timer`:
  - Parameter TIMEOUT_CYCLES.
  - Inputs `clr`, `en`; output `expired`.
  - Counter width $clog2(TIMEOUT_CYCLES).
- Top level contains the FSM, the credit accumulator and the output registers.

## Test plan
- Reset, then coins type 2, type 2, then sel=01 → credit 10 then 20; one cycle later cash_valid=1, cash=20, product_sel=01; credit=0 afterwards.
- Coins 25, 25 (credit 50), then another 25 → coin_reject=1, credit stays 50; then a type-2 coin → accepted, credit=60.
- Credit 15, then cancel → refund_valid=1, refund_amount=15 for one cycle; state IDLE; cash_valid never asserts.
- TIMEOUT_CYCLES=16: coin type 1, no further activity → refund_valid with amount 5 exactly 16 cycles after the coin was accepted; a coin at cycle 10 restarts the count.
- Same cycle: cancel + sel_valid + coin_valid with credit 10 → refund of 10, coin_reject=1, no cash_valid; then sel=11 with credit 5 → no issue, credit held.
- Assert rst low mid-COLLECT with credit 30 → all outputs 0 immediately (asynchronously), no refund strobe; then sel_valid in IDLE → ignored.
